// File: rtl/mips_mc_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: FSM states,
// opcode/funct values, ALU control codes and datapath select encodings.
package mips_mc_controller_pkg;

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEMADR  = 4'd2,
      ST_MEMRD   = 4'd3,
      ST_MEMWB   = 4'd4,
      ST_MEMWR   = 4'd5,
      ST_RTYPEEX = 4'd6,
      ST_RTYPEWB = 4'd7,
      ST_BEQEX   = 4'd8,
      ST_ADDIEX  = 4'd9,
      ST_ADDIWB  = 4'd10,
      ST_JEX     = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND    = 3'b000;
   localparam logic [2:0] ALU_OR     = 3'b001;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_UNUSED = 3'b011;
   localparam logic [2:0] ALU_SUB    = 3'b110;
   localparam logic [2:0] ALU_SLT    = 3'b111;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle controller (master) and the 32-bit
// datapath (slave): instruction fields and zero flag in, selects/enables out.
interface mips_mc_controller_if;

   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic [2:0] alu_control;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       pcen;
   logic       illegal_op;

   modport master (
      input  op, funct, zero,
      output alu_control, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
             regwrite, regdst, memtoreg, pcen, illegal_op
   );

   modport slave (
      output op, funct, zero,
      input  alu_control, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
             regwrite, regdst, memtoreg, pcen, illegal_op
   );

endinterface

// File: rtl/mips_mc_controller_alu_dec.sv
// ALU decoder: maps the FSM's ALU operation class and the R-type funct field to
// the 3-bit alu_control code, flagging funct values the ALU does not implement.
module mips_mc_controller_alu_dec
   import mips_mc_controller_pkg::*;
(
   input  aluop_t     aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o,
   output logic       illegal_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      illegal_o     = 1'b0;
      case (aluop_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FUNCT_ADD: alu_control_o = ALU_ADD;
               FUNCT_SUB: alu_control_o = ALU_SUB;
               FUNCT_AND: alu_control_o = ALU_AND;
               FUNCT_OR:  alu_control_o = ALU_OR;
               FUNCT_SLT: alu_control_o = ALU_SLT;
               default: begin
                  alu_control_o = ALU_UNUSED;
                  illegal_o     = 1'b1;
               end
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: sequences FETCH..writeback, decodes op/funct and
// drives the datapath selects, write enables and the branch-gated PC enable.
module mips_mc_controller
   import mips_mc_controller_pkg::*;
#(
   parameter logic EN_BNE = 1'b1,
   parameter logic EN_J   = 1'b1
)(
   input  logic                        clk,
   input  logic                        reset,
   mips_mc_controller_if.master        ctl
);

   state_t state_q, state_d;
   logic   is_sw_q, is_sw_d;
   logic   is_bne_q, is_bne_d;
   logic   op_illegal;
   logic   funct_illegal;

   logic       alusrca, iord, irwrite, memwrite, regwrite, regdst, memtoreg;
   logic       pcwrite, branch;
   logic [1:0] alusrcb, pcsrc;
   aluop_t     aluop;
   logic [2:0] alu_control;

   // Memory direction and branch sense are latched in DECODE so later states never look at op.
   always_comb begin
      state_d    = ST_FETCH;
      is_sw_d    = is_sw_q;
      is_bne_d   = is_bne_q;
      op_illegal = 1'b0;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            is_sw_d  = (ctl.op == OP_SW);
            is_bne_d = (ctl.op == OP_BNE);
            case (ctl.op)
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_RTYPE:     state_d = ST_RTYPEEX;
               OP_BEQ:       state_d = ST_BEQEX;
               OP_ADDI:      state_d = ST_ADDIEX;
               OP_BNE: begin
                  if (EN_BNE) begin
                     state_d = ST_BEQEX;
                  end else begin
                     op_illegal = 1'b1;
                  end
               end
               OP_J: begin
                  if (EN_J) begin
                     state_d = ST_JEX;
                  end else begin
                     op_illegal = 1'b1;
                  end
               end
               default: op_illegal = 1'b1;
            endcase
         end
         ST_MEMADR:  state_d = is_sw_q ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:   state_d = ST_MEMWB;
         ST_RTYPEEX: state_d = funct_illegal ? ST_FETCH : ST_RTYPEWB;
         ST_ADDIEX:  state_d = ST_ADDIWB;
         default:    state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_FETCH;
         is_sw_q  <= 1'b0;
         is_bne_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         is_sw_q  <= is_sw_d;
         is_bne_q <= is_bne_d;
      end
   end

   always_comb begin
      alusrca  = 1'b0;
      alusrcb  = SRCB_REGB;
      pcsrc    = PCSRC_ALU;
      iord     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      aluop    = ALUOP_ADD;
      case (state_q)
         ST_FETCH: begin
            irwrite = 1'b1;
            alusrcb = SRCB_FOUR;
            pcwrite = 1'b1;
         end
         ST_DECODE: alusrcb = SRCB_IMMSH;
         ST_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         ST_MEMRD: iord = 1'b1;
         ST_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         ST_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         ST_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         ST_RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         ST_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
         end
         ST_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         ST_ADDIWB: regwrite = 1'b1;
         ST_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         default: aluop = ALUOP_ADD;
      endcase
   end

   mips_mc_controller_alu_dec u_alu_dec (
      .aluop_i       (aluop),
      .funct_i       (ctl.funct),
      .alu_control_o (alu_control),
      .illegal_o     (funct_illegal)
   );

   assign ctl.alu_control = alu_control;
   assign ctl.alusrca     = alusrca;
   assign ctl.alusrcb     = alusrcb;
   assign ctl.pcsrc       = pcsrc;
   assign ctl.iord        = iord;
   assign ctl.regdst      = regdst;
   assign ctl.memtoreg    = memtoreg;

   // State already sits at FETCH during reset, so only enables need masking to keep selects at FETCH values.
   assign ctl.irwrite    = irwrite  & ~reset;
   assign ctl.memwrite   = memwrite & ~reset;
   assign ctl.regwrite   = regwrite & ~reset;
   assign ctl.pcen       = (pcwrite | (branch & (ctl.zero ^ is_bne_q))) & ~reset;
   assign ctl.illegal_op = (op_illegal | funct_illegal) & ~reset;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: a table of instructions with their
// expected state walk, expected per-cycle outputs queued and compared at negedge.
module tb_mips_mc_controller;

   logic clk = 1'b0;
   logic reset;

   mips_mc_controller_if bus();

   mips_mc_controller #(.EN_BNE(1'b1), .EN_J(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
                          S_MWB = 4'd4, S_MW = 4'd5, S_RE = 4'd6, S_RWB = 4'd7,
                          S_BE = 4'd8, S_AE = 4'd9, S_AWB = 4'd10, S_J = 4'd11,
                          S_DI = 4'd12, S_REI = 4'd13, S_RST = 4'd14;

   localparam logic [6:0] C_ALU = 7'b0000001, C_A = 7'b0000010, C_B = 7'b0000100,
                          C_PC = 7'b0001000, C_IORD = 7'b0010000,
                          C_DST = 7'b0100000, C_M2R = 7'b1000000;

   typedef struct packed {
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       pcen;
      logic       illegal;
      logic       regdst;
      logic       memtoreg;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alu;
      logic [6:0] care;
   } exp_t;

   typedef struct {
      logic [5:0]      op;
      logic [5:0]      funct;
      logic            zero;
      logic [2:0]      n;
      logic [4:0][3:0] steps;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];
   exp_t q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [4:0][3:0] seq(input logic [3:0] a, b, c, d, e);
      return {e, d, c, b, a};
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b011;
      endcase
   endfunction

   function automatic exp_t step_exp(input logic [3:0] k, input logic z,
                                     input logic bne, input logic [5:0] f);
      exp_t e;
      e = '0;
      case (k)
         S_F, S_RST: begin
            e.irwrite = (k == S_F);
            e.pcen    = (k == S_F);
            e.alusrcb = 2'b01;
            e.alu     = 3'b010;
            e.care    = C_ALU | C_A | C_B | C_PC | C_IORD;
         end
         S_D, S_DI: begin
            e.illegal = (k == S_DI);
            e.alusrcb = 2'b11;
            e.alu     = 3'b010;
            e.care    = C_ALU | C_A | C_B;
         end
         S_MA, S_AE: begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            e.alu     = 3'b010;
            e.care    = C_ALU | C_A | C_B;
         end
         S_MR: begin
            e.iord = 1'b1;
            e.care = C_IORD;
         end
         S_MWB: begin
            e.regwrite = 1'b1;
            e.memtoreg = 1'b1;
            e.care     = C_DST | C_M2R;
         end
         S_MW: begin
            e.memwrite = 1'b1;
            e.iord     = 1'b1;
            e.care     = C_IORD;
         end
         S_RE, S_REI: begin
            e.illegal = (k == S_REI);
            e.alusrca = 1'b1;
            e.alu     = (k == S_REI) ? 3'b011 : funct_alu(f);
            e.care    = C_ALU | C_A | C_B;
         end
         S_RWB: begin
            e.regwrite = 1'b1;
            e.regdst   = 1'b1;
            e.care     = C_DST | C_M2R;
         end
         S_BE: begin
            e.pcen    = bne ? ~z : z;
            e.alusrca = 1'b1;
            e.pcsrc   = 2'b01;
            e.alu     = 3'b110;
            e.care    = C_ALU | C_A | C_B | C_PC;
         end
         S_AWB: begin
            e.regwrite = 1'b1;
            e.care     = C_DST | C_M2R;
         end
         S_J: begin
            e.pcen  = 1'b1;
            e.pcsrc = 2'b10;
            e.care  = C_PC;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic check(input string tag);
      exp_t e;
      logic ok;
      n_checks++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, nothing expected", tag);
      end else begin
         e  = q.pop_front();
         ok = 1'b1;
         if ({bus.irwrite, bus.memwrite, bus.regwrite, bus.pcen, bus.illegal_op} !==
             {e.irwrite, e.memwrite, e.regwrite, e.pcen, e.illegal}) ok = 1'b0;
         if (e.care[0] && bus.alu_control !== e.alu)     ok = 1'b0;
         if (e.care[1] && bus.alusrca     !== e.alusrca) ok = 1'b0;
         if (e.care[2] && bus.alusrcb     !== e.alusrcb) ok = 1'b0;
         if (e.care[3] && bus.pcsrc       !== e.pcsrc)   ok = 1'b0;
         if (e.care[4] && bus.iord        !== e.iord)    ok = 1'b0;
         if (e.care[5] && bus.regdst      !== e.regdst)  ok = 1'b0;
         if (e.care[6] && bus.memtoreg    !== e.memtoreg) ok = 1'b0;
         if (!ok) begin
            n_fail++;
            $display("FAIL %s: got ir/mw/rw/pcen/ill=%b alu=%b a=%b b=%b pcsrc=%b iord=%b dst=%b m2r=%b; want %b alu=%b a=%b b=%b pcsrc=%b iord=%b dst=%b m2r=%b care=%b",
                     tag, {bus.irwrite, bus.memwrite, bus.regwrite, bus.pcen, bus.illegal_op},
                     bus.alu_control, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.iord,
                     bus.regdst, bus.memtoreg,
                     {e.irwrite, e.memwrite, e.regwrite, e.pcen, e.illegal},
                     e.alu, e.alusrca, e.alusrcb, e.pcsrc, e.iord, e.regdst, e.memtoreg, e.care);
         end
      end
   endtask

   // Runs steps [start, stop) of vector vi; entered and left at posedge+1.
   task automatic run_instr(input int vi, input int start, input int stop);
      bus.op    = vecs[vi].op;
      bus.funct = vecs[vi].funct;
      bus.zero  = vecs[vi].zero;
      for (int s = start; s < stop; s++) begin
         q.push_back(step_exp(vecs[vi].steps[s], vecs[vi].zero,
                              vecs[vi].op == 6'b000101, vecs[vi].funct));
         @(negedge clk);
         check($sformatf("vec%0d_step%0d", vi, s));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{6'b100011, 6'b000000, 1'b1, 3'd5, seq(S_F, S_D, S_MA, S_MR, S_MWB)};
      vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 3'd4, seq(S_F, S_D, S_MA, S_MW, S_F)};
      vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 3'd4, seq(S_F, S_D, S_RE, S_RWB, S_F)};
      vecs[3]  = '{6'b000000, 6'b100010, 1'b1, 3'd4, seq(S_F, S_D, S_RE, S_RWB, S_F)};
      vecs[4]  = '{6'b000000, 6'b100100, 1'b0, 3'd4, seq(S_F, S_D, S_RE, S_RWB, S_F)};
      vecs[5]  = '{6'b000000, 6'b100101, 1'b0, 3'd4, seq(S_F, S_D, S_RE, S_RWB, S_F)};
      vecs[6]  = '{6'b000000, 6'b101010, 1'b0, 3'd4, seq(S_F, S_D, S_RE, S_RWB, S_F)};
      vecs[7]  = '{6'b000000, 6'b000000, 1'b0, 3'd3, seq(S_F, S_D, S_REI, S_F, S_F)};
      vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 3'd3, seq(S_F, S_D, S_BE, S_F, S_F)};
      vecs[9]  = '{6'b000100, 6'b000000, 1'b0, 3'd3, seq(S_F, S_D, S_BE, S_F, S_F)};
      vecs[10] = '{6'b000101, 6'b000000, 1'b1, 3'd3, seq(S_F, S_D, S_BE, S_F, S_F)};
      vecs[11] = '{6'b000101, 6'b000000, 1'b0, 3'd3, seq(S_F, S_D, S_BE, S_F, S_F)};
      vecs[12] = '{6'b001000, 6'b000000, 1'b0, 3'd4, seq(S_F, S_D, S_AE, S_AWB, S_F)};
      vecs[13] = '{6'b000010, 6'b000000, 1'b0, 3'd3, seq(S_F, S_D, S_J, S_F, S_F)};
      vecs[14] = '{6'b111111, 6'b000000, 1'b0, 3'd2, seq(S_F, S_DI, S_F, S_F, S_F)};
      vecs[15] = '{6'b001100, 6'b100000, 1'b1, 3'd2, seq(S_F, S_DI, S_F, S_F, S_F)};

      reset     = 1'b1;
      bus.op    = 6'b100011;
      bus.funct = 6'b000000;
      bus.zero  = 1'b0;
      q.push_back(step_exp(S_RST, 1'b0, 1'b0, 6'b000000));
      @(negedge clk);
      check("reset_hold");
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int v = 0; v < NV; v++) begin
         run_instr(v, 0, int'(vecs[v].n));
      end

      // sw interrupted by reset while in MEMWR
      run_instr(1, 0, 3);
      q.push_back(step_exp(S_MW, 1'b0, 1'b0, 6'b000000));
      @(negedge clk);
      check("memwr_before_reset");
      #1 reset = 1'b1;
      #1;
      q.push_back(step_exp(S_RST, 1'b0, 1'b0, 6'b000000));
      check("memwr_reset_same_cycle");
      #1 reset = 1'b0;
      #1;
      q.push_back(step_exp(S_F, 1'b0, 1'b0, 6'b000000));
      check("fetch_after_release");
      @(posedge clk);
      #1;
      run_instr(1, 1, int'(vecs[1].n));

      // back-to-back lw then illegal op to confirm the sequencer restarts cleanly
      run_instr(0, 0, int'(vecs[0].n));
      run_instr(14, 0, int'(vecs[14].n));
      run_instr(6, 0, int'(vecs[6].n));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
